// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle 8-bit-ISA datapath (add, lw, sw, j).
// The FETCH/DECODE/EXEC/MEM/WB state machine fetches instructions over a
// req/valid handshake and owns the register file, data memory and PC.
// Optional feature: define MC_DATAPATH_RETIRE_CNT_EN to add a 16-bit
// retired-instruction counter output (retire_cnt).
module mc_datapath #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PC_W       = 8,
    parameter int unsigned DMEM_DEPTH = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        instruction,
    input  logic              instr_valid,
    output logic              instr_req,
    output logic [PC_W-1:0]   PC,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic              retire
`ifdef MC_DATAPATH_RETIRE_CNT_EN
    ,
    output logic [15:0]       retire_cnt
`endif
);

    // Memory address is taken from the low bits of the effective address;
    // DMEM_DEPTH is assumed not to exceed 2^DATA_W.
    localparam int unsigned AddrW = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpLw  = 2'b01;
    localparam logic [1:0] OpSw  = 2'b10;
    localparam logic [1:0] OpJ   = 2'b11;

    state_e state_q, state_d;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q;
    logic [DATA_W-1:0] a_q, b_q, aluout_q, mdr_q;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

    logic pc_we, ir_we, ab_we, alu_we, mdr_we, mem_we, rf_we;

    logic [1:0]        op, rs, rt, rd;
    logic [DATA_W-1:0] imm2_ext;
    logic [PC_W-1:0]   imm6_ext;
    logic [DATA_W-1:0] alu_result;
    logic [AddrW-1:0]  dmem_addr;
    logic [1:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign op = ir_q[7:6];
    assign rs = ir_q[5:4];
    assign rt = ir_q[3:2];
    assign rd = ir_q[1:0];

    // Sign-extend imm2 to DATA_W and imm6 to PC_W.
    always_comb begin
        imm2_ext = '0;
        imm6_ext = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            imm2_ext[i] = (i < 2) ? ir_q[i] : ir_q[1];
        end
        for (int i = 0; i < int'(PC_W); i++) begin
            imm6_ext[i] = (i < 6) ? ir_q[i] : ir_q[5];
        end
    end

    assign alu_result = (op == OpAdd) ? a_q + b_q : a_q + imm2_ext;
    assign dmem_addr  = aluout_q[AddrW-1:0];
    assign rf_waddr   = (op == OpAdd) ? rd : rt;
    assign rf_wdata   = (op == OpAdd) ? aluout_q : mdr_q;
    assign pc_d       = (op == OpJ) ? pc_q + PC_W'(1) + imm6_ext : pc_q + PC_W'(1);

    assign PC       = pc_q;
    assign dbg_data = rf_q[dbg_sel];

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state register write enables.
    always_comb begin
        state_d   = state_q;
        instr_req = 1'b0;
        retire    = 1'b0;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        ab_we     = 1'b0;
        alu_we    = 1'b0;
        mdr_we    = 1'b0;
        mem_we    = 1'b0;
        rf_we     = 1'b0;
        unique case (state_q)
            StFetch: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ab_we   = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                if (op == OpJ) begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = StFetch;
                end else begin
                    alu_we  = 1'b1;
                    state_d = (op == OpAdd) ? StWb : StMem;
                end
            end
            StMem: begin
                if (op == OpSw) begin
                    mem_we  = 1'b1;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = StFetch;
                end else begin
                    mdr_we  = 1'b1;
                    state_d = StWb;
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
        // A reset cycle aborts the instruction, so it never retires.
        if (RESET) begin
            retire = 1'b0;
        end
    end

    // PC and internal pipeline-less datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            if (pc_we) begin
                pc_q <= pc_d;
            end
            if (ir_we) begin
                ir_q <= instruction;
            end
            if (ab_we) begin
                a_q <= rf_q[rs];
                b_q <= rf_q[rt];
            end
            if (alu_we) begin
                aluout_q <= alu_result;
            end
            if (mdr_we) begin
                mdr_q <= dmem_q[dmem_addr];
            end
        end
    end

    // Register file: cleared by reset, written in WB.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Data memory: reset loads each word with its own index, sw writes in MEM.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
                dmem_q[i] <= DATA_W'(i);
            end
        end else if (mem_we) begin
            dmem_q[dmem_addr] <= b_q;
        end
    end

`ifdef MC_DATAPATH_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q;

    // Free-running count of retired instructions, wraps at 16 bits.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + 16'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multi-cycle, parametrised successor to the single-cycle 8-bit datapath. It executes the 8-bit four-opcode ISA (add, lw, sw, j) through a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction fetch uses a req/valid handshake, so the instruction memory may stall. It owns the register file, data memory and PC, and exposes the PC and a debug register read port for the board display.

## Interface
Parameters:
- DATA_W, 8: register/data-memory word width (≥4).
- PC_W, 8: PC width; PC wraps modulo 2^PC_W.
- DMEM_DEPTH, 32: data-memory words, power of two; address = low log2(DMEM_DEPTH) bits of the effective address.

Ports:
- CLK, in, 1: single clock; all state changes on rising edge.
- RESET, in, 1: synchronous, active-high reset.
- instruction, in, 8: fetched instruction; sampled only in FETCH when instr_valid=1.
- instr_valid, in, 1: instruction word is valid this cycle.
- instr_req, out, 1: high exactly while in FETCH (decoded from the state register).
- PC, out, PC_W: current PC register.
- dbg_sel, in, 2: register index for the debug read.
- dbg_data, out, DATA_W: combinational read of R[dbg_sel].
- retire, out, 1: one-cycle pulse in the final cycle of each instruction.

## Operation
- Instruction fields: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm2; j uses imm6=[5:0].
- Immediates are sign-extended: imm2 to DATA_W, imm6 to PC_W.
- State registers and arrays:
  - 4×DATA_W register file, all general-purpose.
  - IR, A, B, ALUOUT, MDR internal registers.
  - DMEM_DEPTH×DATA_W data memory.
- FETCH:
  - instr_req=1.
  - If instr_valid: IR←instruction, go to DECODE. Otherwise stay in FETCH.
- DECODE: A←R[rs], B←R[rt]; go to EXEC.
- EXEC:
  - op 00 (add): ALUOUT←A+B mod 2^DATA_W; go to WB.
  - op 01/10 (lw/sw): ALUOUT←A+sext(imm2) mod 2^DATA_W; go to MEM.
  - op 11 (j): PC←PC+1+sext(imm6) mod 2^PC_W; retire=1; go to FETCH.
- MEM:
  - lw: MDR←dmem[addr]; go to WB.
  - sw: dmem[addr]←B; PC←PC+1; retire=1; go to FETCH.
- WB:
  - add: R[rd]←ALUOUT. lw: R[rt]←MDR.
  - PC←PC+1; retire=1; go to FETCH.
- Reset, from any state:
  - state=FETCH, PC=0, registers R0–R3=0, IR/A/B/ALUOUT/MDR=0.
  - dmem[i]=i truncated to DATA_W, for every i.
  - retire=0. instr_req=1 from the first cycle after reset.
- Reset mid-instruction aborts it: no register or memory write, no retire.
- instr_valid outside FETCH is ignored; any instruction presented then is not latched.

## Timing
- Cycle 0 is the FETCH cycle with instr_valid=1. Cycles per instruction:
  - add: 4 (F, D, E, WB).
  - lw: 5 (F, D, E, M, WB).
  - sw: 4 (F, D, E, M).
  - j: 3 (F, D, E).
- Each extra cycle with instr_valid=0 in FETCH adds one cycle.
- retire is high in the last cycle; the new PC is visible on the cycle after retire, together with instr_req=1.
- A register write lands at the end of the retire cycle. A dbg_data read of the same register in that cycle shows the old value; it shows the new value from the next cycle.
- PC wraps: PC=2^PC_W−1 followed by add/lw/sw, or by j with imm6=0, gives PC=0.
- A j with imm6=−1 leaves PC unchanged (self-loop).

## Configuration
- MC_DATAPATH_RETIRE_CNT_EN defined:
  - Adds output retire_cnt, 16 bits.
  - retire_cnt increments on every retire pulse and wraps 0xFFFF→0.
  - RESET clears it to 0.
- MC_DATAPATH_RETIRE_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset, then hold instr_valid=0 for 6 cycles → PC=0, instr_req=1 throughout, retire never asserted, dbg_data=0 for every dbg_sel.
- lw 0x47 (rs=0, rt=1, imm=−1) → address 0xFF mod 32 = 31, so R1=31. retire fires exactly 4 cycles after the accepting FETCH; PC=1.
- add 0x16 (R2=R1+R1), then repeated add 0x2A (R2=R2+R2), with R1=31 → R2 takes 62, 124, 248, 240 (8-bit wrap). Each add takes 4 cycles.
- sw 0x96 (rs=1, rt=1, imm=−2) with R1=31 → dmem[29]=31. lw 0x5E (rs=1, rt=3, imm=−2) then gives R3=31.
- j 0xFF → PC unchanged, retire every 3 cycles. j 0xC0 at PC=255 → PC=0.
- RESET asserted in the MEM cycle of a lw to R1 → next cycle state FETCH, PC=0, R1=0, no retire. With the macro defined, retire_cnt=0.
